execute_stage: RTL
==================

Name: execute_stage

Overview:
- RV32I pipelined execute stage, located between the ID/EX register and the memory-access stage.
- Selects forwarded operands, performs ALU operations, resolves branches and jumps, and computes the redirect target.
- Registers the EX/MEM pipeline signals consumed by the memory-access stage: ALU result, store data, rd, memwrite/regwrite enables, wb_sel.
- Contains the forwarding unit and honours the stall and flush inputs from the hazard unit.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-high
- ID_EX_PC  in  32  PC of the instruction in EX
- ID_EX_RD1  in  32  rs1 value read in ID
- ID_EX_RD2  in  32  rs2 value read in ID
- ID_EX_IMM  in  32  sign-extended immediate
- ID_EX_RS1  in  5  rs1 index
- ID_EX_RS2  in  5  rs2 index
- ID_EX_RD  in  5  rd index
- ID_EX_alu_ctrl  in  4  ALU opcode (encoding in Behaviour)
- ID_EX_alu_src  in  1  operand B select: 0 = forwarded rs2, 1 = IMM
- ID_EX_a_sel  in  1  operand A select: 0 = forwarded rs1, 1 = PC (AUIPC)
- ID_EX_branch  in  1  conditional branch
- ID_EX_funct3  in  3  branch condition (RV32I funct3)
- ID_EX_jal  in  1  JAL
- ID_EX_jalr  in  1  JALR
- ID_EX_memwrite_en  in  1  store
- ID_EX_regwrite_en  in  1  register write
- ID_EX_wb_sel  in  2  00 = ALU, 01 = load, 10 = PC+4
- MEM_WB_RD  in  5  WB-stage rd
- MEM_WB_regwrite_en  in  1  WB-stage write enable
- WB_result  in  32  final WB-mux value
- stall  in  1  hold the EX/MEM register
- flush  in  1  squash the instruction in EX
- EX_MEM_ALU_OUT  out  32  registered result
- EX_MEM_writedata  out  32  registered store data
- EX_MEM_RD  out  5  registered rd
- EX_MEM_memwrite_en  out  1  registered store enable
- EX_MEM_regwrite_en  out  1  registered register-write enable
- EX_MEM_wb_sel  out  2  registered writeback select
- pc_src  out  1  combinational redirect request
- pc_target  out  32  combinational redirect target

Behaviour:
- Reset: all EX_MEM_* outputs are 0 and take effect immediately (asynchronous).
  - pc_src is 0 while rst=1.
  - Deasserting reset leaves a bubble.
- Forwarding, operand A; priority order:
  1. If EX_MEM_regwrite_en, EX_MEM_RD != 0, EX_MEM_RD == ID_EX_RS1, and EX_MEM_wb_sel != 01: use EX_MEM_ALU_OUT.
  2. Else if MEM_WB_regwrite_en, MEM_WB_RD != 0, MEM_WB_RD == ID_EX_RS1: use WB_result.
  3. Else: use ID_EX_RD1.
- Forwarding, operand B: same rules using RS2/RD2.
  - The forwarded rs2 is used both as ALU operand B (when alu_src = 0) and as the store data.
  - A load in EX/MEM is never forwarded; the hazard unit inserts a bubble for load-use.
- ALU opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0]
  - 1000 SLT (signed), 1001 SLTU (unsigned)
  - 1010 PASS_B (LUI)
  - Any other code produces 0.
  - Arithmetic wraps modulo 2^32; there is no overflow flag.
- Branch compare uses forwarded rs1 and rs2, independent of alu_ctrl:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
  - 010 and 011 mean not taken.
- Redirect:
  - taken = (branch & cond) | jal | jalr
  - pc_src = taken & ~flush & ~stall & ~rst
  - pc_target for branch and JAL: ID_EX_PC + IMM
  - pc_target for JALR: (forwarded rs1 + IMM) with bit 0 cleared
  - pc_target is don't-care when pc_src = 0.
  - The upstream logic flushes IF/ID and ID/EX on pc_src; this block does not self-flush.
- Result selection: when wb_sel = 10, EX_MEM_ALU_OUT gets ID_EX_PC + 4; otherwise it gets the ALU result.
- EX/MEM register update at each posedge, in priority order:
  1. rst: cleared.
  2. stall: every EX_MEM_* output holds its value.
  3. flush: memwrite_en, regwrite_en and wb_sel go to 0 (bubble); data fields are don't-care and are cleared to 0.
  4. Otherwise: load the new values.
- Simultaneous stall and flush: stall wins (hold), and pc_src = 0.
- Latency: one cycle from ID/EX to EX/MEM. pc_src and pc_target are resolved in the same cycle.
- Reset mid-operation: the register clears immediately and the in-flight instruction is lost.

Test Plan:
- ADD with RD1=5, RD2=7, alu_src=0, rd=3, regwrite=1 -> next cycle EX_MEM_ALU_OUT=12, EX_MEM_RD=3, regwrite=1, memwrite=0.
- Back-to-back dependency: instruction 1 writes x3=12; instruction 2 is ADDI x4,x3,1 with stale RD1=0 -> EX_MEM_ALU_OUT=13. Repeat with the producer in WB (WB_result=12) -> 13. Both stages matching -> EX/MEM wins. rd=0 is never forwarded.
- BNE at PC=0x100, IMM=0x20, rs1=1, rs2=2 -> pc_src=1, pc_target=0x120 in the same cycle. Repeat as BEQ -> pc_src=0. BLT with -1 vs 1 -> taken; BLTU with the same operands -> not taken.
- JALR at PC=0x40 with rs1 forwarded as 0x205, IMM=4, wb_sel=10 -> pc_target=0x208, and next cycle EX_MEM_ALU_OUT=0x44.
- SW with forwarded rs2=0xDEADBEEF, base=0x10, IMM=8 -> EX_MEM_ALU_OUT=0x18, writedata=0xDEADBEEF, memwrite=1. Then stall=1 for 2 cycles -> outputs hold. Then flush=1 -> memwrite and regwrite become 0 and pc_src=0.
- Assert rst asynchronously mid-cycle while EX_MEM_regwrite_en=1 -> all outputs are 0 before the next edge. SRA of 0x80000000 by 4 -> 0xF8000000.

Source files
------------

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   RV32I execute stage. It sits between the ID/EX register and the
//   memory-access stage and does the following:
//     - picks forwarded operands (EX/MEM first, then MEM/WB)
//     - runs the ALU
//     - resolves branches and jumps, driving a combinational redirect
//     - registers the EX/MEM pipeline fields
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   ID_EX_*             : decoded instruction currently in EX
//   MEM_WB_RD/_regwrite : destination and write enable of the WB-stage op
//   WB_result           : final writeback value (MEM/WB forwarding source)
//   stall, flush        : hazard-unit controls for the EX/MEM register
//   EX_MEM_*            : registered outputs to the memory-access stage
//   pc_src, pc_target   : same-cycle redirect request and its target
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ID_EX_PC,
    input  logic [XLEN-1:0] ID_EX_RD1,
    input  logic [XLEN-1:0] ID_EX_RD2,
    input  logic [XLEN-1:0] ID_EX_IMM,
    input  logic [4:0]      ID_EX_RS1,
    input  logic [4:0]      ID_EX_RS2,
    input  logic [4:0]      ID_EX_RD,
    input  logic [3:0]      ID_EX_alu_ctrl,
    input  logic            ID_EX_alu_src,
    input  logic            ID_EX_a_sel,
    input  logic            ID_EX_branch,
    input  logic [2:0]      ID_EX_funct3,
    input  logic            ID_EX_jal,
    input  logic            ID_EX_jalr,
    input  logic            ID_EX_memwrite_en,
    input  logic            ID_EX_regwrite_en,
    input  logic [1:0]      ID_EX_wb_sel,
    input  logic [4:0]      MEM_WB_RD,
    input  logic            MEM_WB_regwrite_en,
    input  logic [XLEN-1:0] WB_result,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] EX_MEM_ALU_OUT,
    output logic [XLEN-1:0] EX_MEM_writedata,
    output logic [4:0]      EX_MEM_RD,
    output logic            EX_MEM_memwrite_en,
    output logic            EX_MEM_regwrite_en,
    output logic [1:0]      EX_MEM_wb_sel,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target
);

    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] writedata_q, writedata_d;
    logic [4:0]      rd_q, rd_d;
    logic            memwrite_en_q, memwrite_en_d;
    logic            regwrite_en_q, regwrite_en_d;
    logic [1:0]      wb_sel_q, wb_sel_d;

    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, jalr_sum;
    logic            cond, taken;

    // Forwarding. A load sitting in EX/MEM has no data yet, so it is
    // excluded; the hazard unit covers load-use with a bubble.
    always_comb begin
        fwd_a = ID_EX_RD1;
        if (regwrite_en_q && (rd_q != 5'd0) && (rd_q == ID_EX_RS1) && (wb_sel_q != WB_LOAD))
            fwd_a = alu_out_q;
        else if (MEM_WB_regwrite_en && (MEM_WB_RD != 5'd0) && (MEM_WB_RD == ID_EX_RS1))
            fwd_a = WB_result;

        fwd_b = ID_EX_RD2;
        if (regwrite_en_q && (rd_q != 5'd0) && (rd_q == ID_EX_RS2) && (wb_sel_q != WB_LOAD))
            fwd_b = alu_out_q;
        else if (MEM_WB_regwrite_en && (MEM_WB_RD != 5'd0) && (MEM_WB_RD == ID_EX_RS2))
            fwd_b = WB_result;
    end

    assign op_a = ID_EX_a_sel   ? ID_EX_PC  : fwd_a;
    assign op_b = ID_EX_alu_src ? ID_EX_IMM : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ID_EX_alu_ctrl)
            4'b0000: alu_res = op_a + op_b;
            4'b0001: alu_res = op_a - op_b;
            4'b0010: alu_res = op_a & op_b;
            4'b0011: alu_res = op_a | op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = op_a << op_b[4:0];
            4'b0110: alu_res = op_a >> op_b[4:0];
            4'b0111: alu_res = $signed(op_a) >>> op_b[4:0];
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b1010: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch compare always uses the forwarded registers, never the ALU.
    always_comb begin
        cond = 1'b0;
        case (ID_EX_funct3)
            3'b000:  cond = (fwd_a == fwd_b);
            3'b001:  cond = (fwd_a != fwd_b);
            3'b100:  cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  cond = (fwd_a <  fwd_b);
            3'b111:  cond = (fwd_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign taken     = (ID_EX_branch & cond) | ID_EX_jal | ID_EX_jalr;
    // A stalled or squashed instruction must not redirect fetch.
    assign pc_src    = taken & ~flush & ~stall & ~rst;
    assign jalr_sum  = fwd_a + ID_EX_IMM;
    assign pc_target = ID_EX_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ID_EX_PC + ID_EX_IMM);

    always_comb begin
        alu_out_d     = alu_out_q;
        writedata_d   = writedata_q;
        rd_d          = rd_q;
        memwrite_en_d = memwrite_en_q;
        regwrite_en_d = regwrite_en_q;
        wb_sel_d      = wb_sel_q;
        if (stall) begin
            // hold everything
        end else if (flush) begin
            alu_out_d     = '0;
            writedata_d   = '0;
            rd_d          = '0;
            memwrite_en_d = 1'b0;
            regwrite_en_d = 1'b0;
            wb_sel_d      = 2'b00;
        end else begin
            alu_out_d     = (ID_EX_wb_sel == WB_PC4) ? (ID_EX_PC + XLEN'(4)) : alu_res;
            writedata_d   = fwd_b;
            rd_d          = ID_EX_RD;
            memwrite_en_d = ID_EX_memwrite_en;
            regwrite_en_d = ID_EX_regwrite_en;
            wb_sel_d      = ID_EX_wb_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q     <= '0;
            writedata_q   <= '0;
            rd_q          <= '0;
            memwrite_en_q <= 1'b0;
            regwrite_en_q <= 1'b0;
            wb_sel_q      <= 2'b00;
        end else begin
            alu_out_q     <= alu_out_d;
            writedata_q   <= writedata_d;
            rd_q          <= rd_d;
            memwrite_en_q <= memwrite_en_d;
            regwrite_en_q <= regwrite_en_d;
            wb_sel_q      <= wb_sel_d;
        end
    end

    assign EX_MEM_ALU_OUT     = alu_out_q;
    assign EX_MEM_writedata   = writedata_q;
    assign EX_MEM_RD          = rd_q;
    assign EX_MEM_memwrite_en = memwrite_en_q;
    assign EX_MEM_regwrite_en = regwrite_en_q;
    assign EX_MEM_wb_sel      = wb_sel_q;

endmodule
